// File: rtl/blinky_sprite.sv
// blinky_sprite: renders the Blinky ghost sprite as a 3-bit palette colour per beam pixel (0 = transparent).
//   clk        system clock
//   reset      synchronous, active-high; clears col and the animation counter
//   ce         pixel-update enable; col is forced to 0 when low
//   shpos      beam horizontal position (10 bits)
//   svpos      beam vertical position (10 bits)
//   xpos/ypos  ghost grid cell, 16x16 pixels per cell
//   direction  facing: 0 up, 1 left, 2 down, 3 right
//   col        registered pixel colour, one cycle after shpos/svpos
//   `define BLINKY_ANIM_EN to animate the skirt; otherwise frame 0 is always shown.
module blinky_sprite #(
    parameter logic [2:0] BODY_COLOR  = 3'd4,
    parameter logic [2:0] EYE_COLOR   = 3'd7,
    parameter logic [2:0] PUPIL_COLOR = 3'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [9:0] shpos,
    input  logic [9:0] svpos,
    input  logic [4:0] xpos,
    input  logic [4:0] ypos,
    input  logic [1:0] direction,
    output logic [2:0] col
);
    logic [2:0] bx, by, pix;
    logic       hit, frame, body, eye, pupil;
`ifdef BLINKY_ANIM_EN
    logic [3:0] anim_cnt;
    always_ff @(posedge clk)
        if (reset) anim_cnt <= 4'd0;
        else if (shpos == 10'd0 && svpos == 10'd0) anim_cnt <= anim_cnt + 4'd1;
    assign frame = anim_cnt[3];
`else
    assign frame = 1'b0;
`endif
    // Pupil: vertical facings pick the eye row by by[0], horizontal facings pick
    // the column by bx[0] (left eye columns 1/5 are odd, right columns 2/6 even).
    always_comb begin
        bx    = shpos[3:1];
        by    = svpos[3:1];
        hit   = !shpos[9] && !svpos[9] && shpos[8:4] == xpos && svpos[8:4] == ypos;
        body  = by == 3'd0 ? (bx >= 3'd2 && bx <= 3'd5) :
                by == 3'd1 ? (bx >= 3'd1 && bx <= 3'd6) :
                by == 3'd7 ? (bx[0] == frame) : 1'b1;
        eye   = (by == 3'd2 || by == 3'd3) &&
                (bx == 3'd1 || bx == 3'd2 || bx == 3'd5 || bx == 3'd6);
        pupil = eye && (direction[0] ? (bx[0] ^ direction[1]) : (by[0] == direction[1]));
        pix   = !hit ? 3'd0 : pupil ? PUPIL_COLOR : eye ? EYE_COLOR : body ? BODY_COLOR : 3'd0;
    end
    always_ff @(posedge clk)
        if (reset) col <= 3'd0;
        else col <= ce ? pix : 3'd0;
endmodule

// File: tb/tb_blinky_sprite.sv
// tb_blinky_sprite: randomized and directed checks of blinky_sprite against a bitmap reference model.
module tb_blinky_sprite;
`ifdef BLINKY_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset, ce;
    logic [9:0] shpos, svpos;
    logic [4:0] xpos, ypos;
    logic [1:0] direction;
    logic [2:0] col;
    int checks = 0;
    int errors = 0;
    int starts = 0;

    blinky_sprite dut (
        .clk(clk), .reset(reset), .ce(ce), .shpos(shpos), .svpos(svpos),
        .xpos(xpos), .ypos(ypos), .direction(direction), .col(col)
    );

    always #5 clk = ~clk;

    // number of frame starts seen since the last reset
    always @(posedge clk)
        if (reset) starts <= 0;
        else if (shpos == 0 && svpos == 0) starts <= starts + 1;

    function automatic logic [2:0] model(int h, int v, int x, int y, int d, bit en, int n);
        byte body_rows [8];
        int bx, by, lx, ly, frame;
        bit eye, pupil;
        if (!en || h >= 512 || v >= 512 || h / 16 != x || v / 16 != y) return 3'd0;
        frame = ANIM ? (n / 8) % 2 : 0;
        body_rows = '{8'b00111100, 8'b01111110, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      frame ? 8'b10101010 : 8'b01010101};
        bx = (h % 16) / 2;
        by = (v % 16) / 2;
        eye = (by == 2 || by == 3) && (bx == 1 || bx == 2 || bx == 5 || bx == 6);
        lx = bx < 4 ? bx - 1 : bx - 5;
        ly = by - 2;
        pupil = eye && ((d == 0 && ly == 0) || (d == 2 && ly == 1) ||
                        (d == 1 && lx == 0) || (d == 3 && lx == 1));
        if (pupil) return 3'd1;
        if (eye) return 3'd7;
        if (body_rows[by][bx]) return 3'd4;
        return 3'd0;
    endfunction

    // drive one pixel for one clock; returns the model expectation for it
    task automatic pixel(input int h, input int v, output logic [2:0] exp);
        shpos = h[9:0];
        svpos = v[9:0];
        exp = model(h, v, xpos, ypos, direction, ce && !reset, starts);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [2:0] e;
        xpos = 2; ypos = 2; direction = 0; ce = 1;
        reset = 1;
        pixel(36, 36, e);
        checks++;
        if (col !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", col); end
        reset = 0;
        pixel(32, 46, e);
        checks++;
        if (col !== 3'd4 || e !== 3'd4) begin errors++; $display("FAIL reset_frame0 got %0d want 4", col); end
    endtask

    task automatic test_eyes;
        logic [2:0] e;
        int dirs [4] = '{0, 2, 3, 1};
        logic [2:0] want [4] = '{3'd1, 3'd7, 3'd1, 3'd7};
        for (int i = 0; i < 4; i++) begin
            direction = dirs[i][1:0];
            pixel(36, 36, e);
            checks++;
            if (col !== want[i] || e !== want[i])
                begin errors++; $display("FAIL eye_dir%0d got %0d want %0d", dirs[i], col, want[i]); end
        end
    endtask

    task automatic test_shape;
        logic [2:0] e;
        int hs [4] = '{38, 32, 31, 48};
        int vs [4] = '{32, 32, 36, 36};
        logic [2:0] want [4] = '{3'd4, 3'd0, 3'd0, 3'd0};
        direction = 0;
        for (int i = 0; i < 4; i++) begin
            pixel(hs[i], vs[i], e);
            checks++;
            if (col !== want[i] || e !== want[i])
                begin errors++; $display("FAIL shape(%0d,%0d) got %0d want %0d", hs[i], vs[i], col, want[i]); end
        end
    endtask

    task automatic test_enable;
        logic [2:0] e;
        ce = 0;
        pixel(38, 40, e);
        checks++;
        if (col !== 3'd0) begin errors++; $display("FAIL enable_off got %0d want 0", col); end
        ce = 1;
        pixel(38, 40, e);
        checks++;
        if (col !== 3'd4) begin errors++; $display("FAIL enable_on got %0d want 4", col); end
    endtask

    task automatic test_animation;
        logic [2:0] e, want;
        reset = 1;
        pixel(100, 100, e);
        reset = 0;
        for (int k = 0; k <= 17; k++) begin
            pixel(32, 46, e);
            want = (ANIM && k >= 8 && k < 16) ? 3'd0 : 3'd4;
            checks++;
            if (col !== want || e !== want)
                begin errors++; $display("FAIL anim_after%0d got %0d want %0d", k, col, want); end
            ce = 0;
            pixel(0, 0, e);
            ce = 1;
        end
    endtask

    task automatic test_reset_midframe;
        logic [2:0] e;
        for (int k = 0; k < 9; k++) pixel(0, 0, e);
        reset = 1;
        pixel(32, 46, e);
        checks++;
        if (col !== 3'd0) begin errors++; $display("FAIL midreset_col got %0d want 0", col); end
        reset = 0;
        pixel(32, 46, e);
        checks++;
        if (col !== 3'd4) begin errors++; $display("FAIL midreset_frame0 got %0d want 4", col); end
    endtask

    task automatic test_bit9;
        logic [2:0] e;
        xpos = 0; ypos = 0;
        pixel(516, 4, e);
        checks++;
        if (col !== 3'd0) begin errors++; $display("FAIL bit9_h got %0d want 0", col); end
        pixel(4, 516, e);
        checks++;
        if (col !== 3'd0) begin errors++; $display("FAIL bit9_v got %0d want 0", col); end
    endtask

    task automatic test_random;
        logic [2:0] e;
        int h, v;
        for (int i = 0; i < 600; i++) begin
            xpos = 5'($urandom);
            ypos = 5'($urandom);
            direction = 2'($urandom);
            ce = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 5))
                0: begin h = $urandom_range(0, 1023); v = $urandom_range(0, 1023); end
                1: begin h = 0; v = 0; end
                2: begin h = xpos * 16 + 512 + $urandom_range(0, 15); v = ypos * 16 + $urandom_range(0, 15); end
                default: begin h = xpos * 16 + $urandom_range(0, 15); v = ypos * 16 + $urandom_range(0, 15); end
            endcase
            pixel(h, v, e);
            checks++;
            if (col !== e)
                begin errors++; $display("FAIL rand(%0d,%0d,x%0d,y%0d,d%0d) got %0d want %0d", h, v, xpos, ypos, direction, col, e); end
        end
    endtask

    initial begin
        reset = 1; ce = 0; shpos = 0; svpos = 0; xpos = 0; ypos = 0; direction = 0;
        test_reset;
        test_eyes;
        test_shape;
        test_enable;
        test_animation;
        test_reset_midframe;
        test_bit9;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
